// File: rtl/alu_74181_pkg.sv
// Shared types for the 74181 command sequencer (state enum, nibble type, FIFO entry width).
// Latency: n/a (types and constants only).
// Backpressure: n/a. ALU_74181_AEQB_FLAG_EN widens each result entry with the A=B flag.
package alu_74181_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        LOAD_S = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        EXEC   = 2'd3
    } cmd_state_t;

`ifdef ALU_74181_AEQB_FLAG_EN
    // Result nibble plus the all-ones (A=B) flag in the MSB.
    localparam int ENTRY_W = NIBBLE_W + 1;
`else
    localparam int ENTRY_W = NIBBLE_W;
`endif

endpackage

// File: rtl/alu_74181_result_fifo.sv
// Circular result buffer between the sequencer and the chip-level output handshake.
// Latency: entry visible at head_data the cycle after push (no fall-through).
// Backpressure: push accepted when not full or when popping the same cycle; pop on empty ignored.
module alu_74181_result_fifo #(
    parameter int RES_DEPTH = 2,
    parameter int ENTRY_W   = 4,
    parameter int CNT_W     = $clog2(RES_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head_data,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(RES_DEPTH);

    logic [ENTRY_W-1:0] mem_q [RES_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_pop;
    logic               do_push;

    assign full      = (count_q == CNT_W'(RES_DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers (wrap naturally since depth is a power of two) and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_74181_cmd_seq.sv
// Sequences S/A/B command beats into the 74181 logic unit and queues its results.
// Latency: result pushed one edge after the B beat is accepted; out_valid the cycle after.
// Backpressure: in_ready low in EXEC; EXEC stalls while the result FIFO is full. Optional port
// out_aeqb is enabled by ALU_74181_AEQB_FLAG_EN.
module alu_74181_cmd_seq
    import alu_74181_pkg::*;
#(
    parameter int RES_DEPTH = 2,
    parameter int CNT_W     = $clog2(RES_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic [3:0]       alu_s,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_f,
    output logic [3:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] res_count
`ifdef ALU_74181_AEQB_FLAG_EN
    ,
    output logic             out_aeqb
`endif
);

    cmd_state_t         state_q;
    nibble_t            s_q;
    nibble_t            a_q;
    nibble_t            b_q;
    logic               beat_acc;
    logic               pop;
    logic               exec_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;

    assign alu_s = s_q;
    assign alu_a = a_q;
    assign alu_b = b_q;

    // abort blocks any beat so a partial command never half-loads a register.
    assign in_ready  = (state_q != EXEC) && !abort;
    assign beat_acc  = in_valid && in_ready;
    assign pop       = !fifo_empty && out_ready;
    assign exec_push = (state_q == EXEC) && !abort && (!fifo_full || pop);

`ifdef ALU_74181_AEQB_FLAG_EN
    assign push_data = {&alu_f, alu_f};
    assign out_aeqb  = head_data[NIBBLE_W];
`else
    assign push_data = alu_f;
`endif

    assign out_data  = head_data[NIBBLE_W-1:0];
    assign out_valid = !fifo_empty;
    assign busy      = (state_q != LOAD_S) || !fifo_empty;

    // Command FSM; operand registers hold through EXEC so alu_f stays stable during a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_S;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (abort) begin
            state_q <= LOAD_S;
        end else begin
            case (state_q)
                LOAD_S: if (beat_acc) begin
                    s_q     <= in_data;
                    state_q <= LOAD_A;
                end
                LOAD_A: if (beat_acc) begin
                    a_q     <= in_data;
                    state_q <= LOAD_B;
                end
                LOAD_B: if (beat_acc) begin
                    b_q     <= in_data;
                    state_q <= EXEC;
                end
                EXEC: if (exec_push) begin
                    state_q <= LOAD_S;
                end
                default: state_q <= LOAD_S;
            endcase
        end
    end

    alu_74181_result_fifo #(
        .RES_DEPTH (RES_DEPTH),
        .ENTRY_W   (ENTRY_W),
        .CNT_W     (CNT_W)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (exec_push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (res_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_alu_74181_cmd_seq.sv
// Bench for the 74181 command sequencer with a behavioural logic-unit model on alu_f.
// Latency: directed timing checks plus a random command run checked against a result queue.
// Backpressure: out_ready held low, toggled randomly and high to exercise stalls and drains.
module tb_alu_74181_cmd_seq;

    localparam int RES_DEPTH = 2;
    localparam int CNT_W     = $clog2(RES_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic [3:0]       alu_s;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_f;
    logic [3:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] res_count;
`ifdef ALU_74181_AEQB_FLAG_EN
    logic             out_aeqb;
`endif

    int tests = 0;
    int fails = 0;
    logic [4:0] exp_q[$];

    // 74181 logic mode (M=1), active-high data: one function per select code.
    function automatic logic [3:0] ref_f(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            4'h0: return ~a;
            4'h1: return ~(a | b);
            4'h2: return ~a & b;
            4'h3: return 4'h0;
            4'h4: return ~(a & b);
            4'h5: return ~b;
            4'h6: return a ^ b;
            4'h7: return a & ~b;
            4'h8: return ~a | b;
            4'h9: return ~(a ^ b);
            4'hA: return b;
            4'hB: return a & b;
            4'hC: return 4'hF;
            4'hD: return a | ~b;
            4'hE: return a | b;
            default: return a;
        endcase
    endfunction

    assign alu_f = ref_f(alu_s, alu_a, alu_b);

    always #5 clk = ~clk;

    alu_74181_cmd_seq #(.RES_DEPTH(RES_DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .res_count (res_count)
`ifdef ALU_74181_AEQB_FLAG_EN
        ,
        .out_aeqb  (out_aeqb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [3:0] d, input bit rnd_rdy);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        while (!in_ready && n < 50) begin
            step(1);
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("beat_accept", in_ready, 1);
        step(1);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic send_cmd(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b,
                            input bit expect_res, input bit rnd_rdy);
        logic [3:0] f;
        f = ref_f(s, a, b);
        send_beat(s, rnd_rdy);
        send_beat(a, rnd_rdy);
        send_beat(b, rnd_rdy);
        if (expect_res) exp_q.push_back({&f, f});
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step(12);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_count", res_count, 0);
        check("drain_busy", busy, 0);
    endtask

    // Every pop the DUT is about to perform must deliver the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            check("pop_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("pop_data", out_data, e[3:0]);
`ifdef ALU_74181_AEQB_FLAG_EN
                check("pop_aeqb", out_aeqb, e[4]);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = 4'h0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        step(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", res_count, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_s", alu_s, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step(1);

        // 1: XOR command, latency and drain.
        out_ready = 1'b1;
        send_cmd(4'h6, 4'hC, 4'hA, 1'b1, 1'b0);
        check("t1_exec_no_valid", out_valid, 0);
        check("t1_exec_in_ready", in_ready, 0);
        step(1);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 4'h6);
        check("t1_count", res_count, 1);
        step(1);
        check("t1_count_empty", res_count, 0);
        check("t1_busy", busy, 0);

        // 2: fill FIFO, stall EXEC, release with a simultaneous pop+push.
        out_ready = 1'b0;
        send_cmd(4'hF, 4'h3, 4'($urandom), 1'b1, 1'b0);
        send_cmd(4'hA, 4'($urandom), 4'h5, 1'b1, 1'b0);
        send_cmd(4'hC, 4'($urandom), 4'($urandom), 1'b1, 1'b0);
        step(2);
        check("t2_stall_in_ready", in_ready, 0);
        check("t2_stall_busy", busy, 1);
        check("t2_stall_count", res_count, 2);
        check("t2_head", out_data, 4'h3);
        out_ready = 1'b1;
        step(1);
        check("t2_pop_push_count", res_count, 2);
        step(1);
        check("t2_count1", res_count, 1);
        step(1);
        check("t2_count0", res_count, 0);
        check("t2_all_popped", exp_q.size(), 0);

        // 3: abort in LOAD_B with a beat offered.
        send_beat(4'h6, 1'b0);
        send_beat(4'h9, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'h7;
        abort    = 1'b1;
        #1;
        check("t3_abort_in_ready", in_ready, 0);
        step(1);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t3_back_to_load_s", in_ready, 1);
        check("t3_busy", busy, 0);
        step(2);
        check("t3_no_result", out_valid, 0);
        send_cmd(4'hE, 4'h9, 4'h4, 1'b1, 1'b0);
        drain();

        // 4: abort during an EXEC stall drops the pending result.
        out_ready = 1'b0;
        send_cmd(4'h1, 4'h2, 4'h4, 1'b1, 1'b0);
        send_cmd(4'h7, 4'hE, 4'h3, 1'b1, 1'b0);
        send_cmd(4'hB, 4'hF, 4'h6, 1'b0, 1'b0);
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        #1;
        check("t4_count", res_count, 2);
        check("t4_busy", busy, 1);
        check("t4_in_ready", in_ready, 1);
        step(3);
        check("t4_count_held", res_count, 2);
        drain();

        // 5: reset mid-command with one entry queued.
        out_ready = 1'b0;
        send_cmd(4'h0, 4'h5, 4'h0, 1'b1, 1'b0);
        step(2);
        check("t5_count_before", res_count, 1);
        send_beat(4'h4, 1'b0);
        send_beat(4'hD, 1'b0);
        rst_n = 1'b0;
        step(1);
        exp_q.delete();
        check("t5_out_valid", out_valid, 0);
        check("t5_count", res_count, 0);
        check("t5_alu_s", alu_s, 0);
        check("t5_alu_a", alu_a, 0);
        check("t5_alu_b", alu_b, 0);
        check("t5_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step(1);

`ifdef ALU_74181_AEQB_FLAG_EN
        // 6: A=B flag on an all-ones result and on a non-all-ones result.
        out_ready = 1'b0;
        send_cmd(4'h9, 4'h5, 4'h5, 1'b1, 1'b0);
        step(1);
        check("t6_data_eq", out_data, 4'hF);
        check("t6_aeqb_eq", out_aeqb, 1);
        drain();
        out_ready = 1'b0;
        send_cmd(4'h9, 4'h5, 4'h4, 1'b1, 1'b0);
        step(1);
        check("t6_data_ne", out_data, 4'hE);
        check("t6_aeqb_ne", out_aeqb, 0);
        drain();
`endif

        // Random commands under random output backpressure.
        for (int i = 0; i < 40; i++) begin
            send_cmd(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_74181_cmd_seq.md
Name: alu_74181_cmd_seq

Overview:
Command sequencer directly upstream of alu_74181_logic, driving its a/b/s inputs and capturing its f output.
- Accepts a 4-bit-wide command stream of three beats (S, A, B) over a valid/ready handshake.
- Holds the operands stable for one execute cycle and captures the combinational result.
- Buffers results in a small FIFO with a valid/ready output handshake for the chip-level I/O mux.

Parameters:
RES_DEPTH, 2, result FIFO entries; power of two, 2..8
CNT_W, $clog2(RES_DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  4  command beat: S, then A, then B
in_valid  input  1  in_data valid
in_ready  output  1  beat accepted when in_valid && in_ready
abort  input  1  discard the partial command and return to LOAD_S
alu_s  output  4  function select to the logic unit
alu_a  output  4  operand A to the logic unit
alu_b  output  4  operand B to the logic unit
alu_f  input  4  result from the logic unit, combinational
out_data  output  4  FIFO head result
out_valid  output  1  FIFO not empty
out_ready  input  1  pop when out_valid && out_ready
busy  output  1  state != LOAD_S or FIFO not empty
res_count  output  CNT_W  FIFO occupancy

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=LOAD_S; s_reg/a_reg/b_reg=0, so alu_s/alu_a/alu_b=0.
  - FIFO pointers and count =0; out_valid=0, out_data=0, res_count=0, busy=0.
  - Reset mid-command or mid-FIFO discards everything.
- alu_s/alu_a/alu_b are driven directly from s_reg/a_reg/b_reg. They change only on accepted beats or reset.
- FSM states: LOAD_S, LOAD_A, LOAD_B, EXEC.
  - LOAD_S: in_ready=!abort. On accept: s_reg<=in_data, go to LOAD_A.
  - LOAD_A: same, loads a_reg, go to LOAD_B.
  - LOAD_B: same, loads b_reg, go to EXEC.
  - EXEC: in_ready=0.
    - If FIFO can accept (count<RES_DEPTH, or count==RES_DEPTH with a pop in the same cycle): push alu_f, go to LOAD_S.
    - Otherwise stay in EXEC (stall); registers are held, so alu_f stays stable.
- abort:
  - Any state: next state=LOAD_S, no beat accepted, no push.
  - abort in EXEC drops the pending result.
  - Operand registers are not cleared by abort.
  - abort has priority over in_valid and over the EXEC push.
- Latency:
  - B accepted at edge N; EXEC during cycle N..N+1; push at edge N+1.
  - out_valid high after edge N+1 when the FIFO was empty.
  - No fall-through.
- Throughput: one result per 4 cycles maximum.
- FIFO:
  - Circular buffer; pointers wrap modulo RES_DEPTH.
  - Simultaneous push and pop: count unchanged, valid in both the full and the empty-with-push case.
  - Pop when empty is ignored.
  - out_data = mem[rd_ptr].
- busy is combinational from state and count.

Optional Feature:
Macro: ALU_74181_AEQB_FLAG_EN.
- With the macro: adds output port out_aeqb (1 bit).
  - Each FIFO entry stores 5 bits: {&alu_f, alu_f}.
  - out_aeqb = stored flag of the head entry; reset value 0.
  - Matches the 74181 A=B open-collector output (all F bits high).
- Without the macro: port absent, entries are 4 bits, no other behavioural change.

Decomposition:
- Package alu_74181_pkg:
  - enum cmd_state_t {LOAD_S, LOAD_A, LOAD_B, EXEC}
  - localparam NIBBLE_W=4
  - typedef logic [NIBBLE_W-1:0] nibble_t
- Sub-module alu_74181_result_fifo:
  - Parameterised by RES_DEPTH and entry width.
  - Ports: push, push_data, pop, head_data, count, full, empty.
- The sequencer instantiates the FIFO.
- The top level connects alu_a/b/s/f to alu_74181_logic.

Test Plan:
1. Reset, then beats S=6, A=C, B=A with out_ready=1 -> out_valid 2 cycles after the B accept, out_data=6 (XOR); res_count returns to 0.
2. out_ready=0; issue 3 commands (S=F A=3; S=A B=5; S=C) -> after 2 results, EXEC stalls, in_ready=0, busy=1. Raise out_ready -> third result pushed on the first pop cycle. Pops yield 3, 5, F in order.
3. abort asserted in LOAD_B with in_valid=1 -> no accept, state LOAD_S, no result. A following full command executes normally.
4. abort during an EXEC stall (FIFO full) -> pending result dropped, res_count stays 2.
5. rst_n low mid-command with the FIFO holding 1 entry -> next cycle out_valid=0, res_count=0, alu_s/a/b=0, in_ready=1.
6. With ALU_74181_AEQB_FLAG_EN: S=9, A=5, B=5 -> out_data=F, out_aeqb=1. S=9, A=5, B=4 -> out_data=E, out_aeqb=0.
